// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT stream types, width constants and helpers
package fft_pkg;

    localparam int FFT_INT_DEPTH = 11;
    localparam int FFT_INT_WIDTH = 20;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } fsm_state_t;

    function automatic int mag_width(input int fft_width);
        return 2 * fft_width;
    endfunction

endpackage

// File: rtl/cplx_mag_sq.sv
// rtl/cplx_mag_sq.sv - two-stage pipelined Re^2 + Im^2 unit
module cplx_mag_sq
    import fft_pkg::*;
#(
    parameter int FFT_WIDTH = 20
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic signed [FFT_WIDTH-1:0]         i_re,
    input  logic signed [FFT_WIDTH-1:0]         i_im,
    output logic [mag_width(FFT_WIDTH)-1:0]     o_mag
);

    localparam int PW = mag_width(FFT_WIDTH);

    logic signed [PW-1:0] w_re_ext;
    logic signed [PW-1:0] w_im_ext;
    logic signed [PW-1:0] r_re_sq;
    logic signed [PW-1:0] r_im_sq;
    logic [PW-1:0]        r_mag;

    assign w_re_ext = {{FFT_WIDTH{i_re[FFT_WIDTH-1]}}, i_re};
    assign w_im_ext = {{FFT_WIDTH{i_im[FFT_WIDTH-1]}}, i_im};

    // Each square is at most 2^(2W-2), so the unsigned sum never exceeds 2^(2W-1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_re_sq <= '0;
            r_im_sq <= '0;
            r_mag   <= '0;
        end else begin
            r_re_sq <= w_re_ext * w_re_ext;
            r_im_sq <= w_im_ext * w_im_ext;
            r_mag   <= $unsigned(r_re_sq) + $unsigned(r_im_sq);
        end
    end

    assign o_mag = r_mag;

endmodule

// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - per-packet strongest-bin detector; FFT_PEAK_SKIP_DC_EN excludes bin 0
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter  int FFT_DEPTH = 11,
    parameter  int FFT_WIDTH = 20,
    localparam int MAG_WIDTH = mag_width(FFT_WIDTH)
) (
    input  logic                        clk,
    input  logic                        aclr,
    input  logic                        sink_sop,
    input  logic                        sink_eop,
    input  logic                        sink_valid,
    input  logic signed [FFT_WIDTH-1:0] sink_Re,
    input  logic signed [FFT_WIDTH-1:0] sink_Im,
    output logic                        peak_valid,
    output logic [FFT_DEPTH-1:0]        peak_bin,
    output logic [MAG_WIDTH-1:0]        peak_mag,
    output logic                        error
);

`ifdef FFT_PEAK_SKIP_DC_EN
    localparam bit SKIP_DC = 1'b1;
`else
    localparam bit SKIP_DC = 1'b0;
`endif
    localparam logic [FFT_DEPTH-1:0] LAST_BIN = '1;
    localparam logic [FFT_DEPTH-1:0] SEED_BIN = FFT_DEPTH'(SKIP_DC);

    fsm_state_t                  r_state;
    logic [FFT_DEPTH-1:0]        r_cnt;
    logic                        r_error;

    logic signed [FFT_WIDTH-1:0] r_s0_re;
    logic signed [FFT_WIDTH-1:0] r_s0_im;
    logic                        r_s0_vld, r_s1_vld, r_s2_vld;
    logic                        r_s0_seed, r_s1_seed, r_s2_seed;
    logic                        r_s0_last, r_s1_last, r_s2_last;
    logic [FFT_DEPTH-1:0]        r_s0_bin, r_s1_bin, r_s2_bin;

    logic [MAG_WIDTH-1:0]        w_mag;
    logic                        w_bin0;
    logic [FFT_DEPTH-1:0]        w_bin;
    logic                        w_part;

    logic [MAG_WIDTH-1:0]        r_max_mag;
    logic [FFT_DEPTH-1:0]        r_max_bin;
    logic                        w_take;
    logic [MAG_WIDTH-1:0]        w_max_mag;
    logic [FFT_DEPTH-1:0]        w_max_bin;

    logic                        r_peak_valid;
    logic [FFT_DEPTH-1:0]        r_peak_bin;
    logic [MAG_WIDTH-1:0]        r_peak_mag;

    // Any sop beat, or any beat accepted from IDLE, is bin 0 of a fresh packet.
    assign w_bin0 = (r_state == IDLE) || sink_sop;
    assign w_bin  = w_bin0 ? '0 : r_cnt;
    assign w_part = !SKIP_DC || (w_bin != '0);

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_error   <= 1'b0;
            r_s0_re   <= '0;
            r_s0_im   <= '0;
            r_s0_vld  <= 1'b0;
            r_s0_seed <= 1'b0;
            r_s0_last <= 1'b0;
            r_s0_bin  <= '0;
        end else begin
            r_error   <= 1'b0;
            r_s0_vld  <= 1'b0;
            r_s0_last <= 1'b0;
            r_s0_re   <= sink_Re;
            r_s0_im   <= sink_Im;
            r_s0_bin  <= w_bin;
            r_s0_seed <= (w_bin == SEED_BIN);
            if (sink_valid) begin
                unique case (r_state)
                    IDLE: begin
                        if (sink_sop && !sink_eop) begin
                            r_state  <= ACTIVE;
                            r_cnt    <= FFT_DEPTH'(1);
                            r_s0_vld <= w_part;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (sink_sop && sink_eop) begin
                            r_error <= 1'b1;
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else if (sink_sop) begin
                            r_error  <= 1'b1;
                            r_cnt    <= FFT_DEPTH'(1);
                            r_s0_vld <= w_part;
                        end else if (sink_eop || (r_cnt == LAST_BIN)) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            if (sink_eop && (r_cnt == LAST_BIN)) begin
                                r_s0_vld  <= w_part;
                                r_s0_last <= 1'b1;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end else begin
                            r_cnt    <= r_cnt + 1'b1;
                            r_s0_vld <= w_part;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    cplx_mag_sq #(
        .FFT_WIDTH (FFT_WIDTH)
    ) u_mag (
        .clk   (clk),
        .rst   (aclr),
        .i_re  (r_s0_re),
        .i_im  (r_s0_im),
        .o_mag (w_mag)
    );

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_s1_vld  <= 1'b0;
            r_s1_seed <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_bin  <= '0;
            r_s2_vld  <= 1'b0;
            r_s2_seed <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_bin  <= '0;
        end else begin
            r_s1_vld  <= r_s0_vld;
            r_s1_seed <= r_s0_seed;
            r_s1_last <= r_s0_last;
            r_s1_bin  <= r_s0_bin;
            r_s2_vld  <= r_s1_vld;
            r_s2_seed <= r_s1_seed;
            r_s2_last <= r_s1_last;
            r_s2_bin  <= r_s1_bin;
        end
    end

    // Strict greater-than keeps the earliest bin on a tie.
    always_comb begin
        w_take    = r_s2_vld && (r_s2_seed || (w_mag > r_max_mag));
        w_max_mag = w_take ? w_mag    : r_max_mag;
        w_max_bin = w_take ? r_s2_bin : r_max_bin;
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_max_mag    <= '0;
            r_max_bin    <= '0;
            r_peak_valid <= 1'b0;
            r_peak_bin   <= '0;
            r_peak_mag   <= '0;
        end else begin
            r_max_mag    <= w_max_mag;
            r_max_bin    <= w_max_bin;
            r_peak_valid <= r_s2_vld && r_s2_last;
            if (r_s2_vld && r_s2_last) begin
                r_peak_bin <= w_max_bin;
                r_peak_mag <= w_max_mag;
            end
        end
    end

    assign peak_valid = r_peak_valid;
    assign peak_bin   = r_peak_bin;
    assign peak_mag   = r_peak_mag;
    assign error      = r_error;

endmodule

// File: tb/tb_fft_peak_detect.sv
// tb/tb_fft_peak_detect.sv - randomized and directed bench against a packet-level reference model
module tb_fft_peak_detect;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int N     = 16;
    localparam int MAXC  = 4096;
`ifdef FFT_PEAK_SKIP_DC_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif

    logic                    clk = 1'b0;
    logic                    aclr = 1'b1;
    logic                    sink_sop = 1'b0;
    logic                    sink_eop = 1'b0;
    logic                    sink_valid = 1'b0;
    logic signed [WIDTH-1:0] sink_Re = '0;
    logic signed [WIDTH-1:0] sink_Im = '0;
    logic                    peak_valid;
    logic [DEPTH-1:0]        peak_bin;
    logic [2*WIDTH-1:0]      peak_mag;
    logic                    error;

    fft_peak_detect #(
        .FFT_DEPTH (DEPTH),
        .FFT_WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .aclr       (aclr),
        .sink_sop   (sink_sop),
        .sink_eop   (sink_eop),
        .sink_valid (sink_valid),
        .sink_Re    (sink_Re),
        .sink_Im    (sink_Im),
        .peak_valid (peak_valid),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit pv_exp  [MAXC];
    bit err_exp [MAXC];
    int bin_exp [MAXC];
    int mag_exp [MAXC];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Packet-level model: bins of the open packet are kept as a list of magnitudes.
    bit in_pkt = 1'b0;
    int mags[$];
    int m_last_bin = 0;
    int m_last_mag = 0;

    function automatic int magsq(input int re, input int im);
        return re * re + im * im;
    endfunction

    task automatic finish_pkt(input int e);
        int best = FIRST;
        for (int i = FIRST + 1; i < N; i++)
            if (mags[i] > mags[best]) best = i;
        pv_exp[e+3]  = 1'b1;
        bin_exp[e+3] = best;
        mag_exp[e+3] = mags[best];
        m_last_bin   = best;
        m_last_mag   = mags[best];
    endtask

    task automatic model_beat(input bit sop, input bit eop, input int re, input int im, input int e);
        int m = magsq(re, im);
        if (!in_pkt) begin
            if (sop && !eop) begin
                in_pkt = 1'b1;
                mags = {m};
            end else begin
                err_exp[e] = 1'b1;
            end
        end else if (sop) begin
            err_exp[e] = 1'b1;
            if (eop) in_pkt = 1'b0;
            else     mags = {m};
        end else if (eop) begin
            in_pkt = 1'b0;
            if (mags.size() == N - 1) begin
                mags.push_back(m);
                finish_pkt(e);
            end else begin
                err_exp[e] = 1'b1;
            end
        end else if (mags.size() == N - 1) begin
            in_pkt = 1'b0;
            err_exp[e] = 1'b1;
        end else begin
            mags.push_back(m);
        end
    endtask

    task automatic drive(input bit v, input bit sop, input bit eop,
                         input logic signed [WIDTH-1:0] re, input logic signed [WIDTH-1:0] im);
        sink_valid = v;
        sink_sop   = sop;
        sink_eop   = eop;
        sink_Re    = re;
        sink_Im    = im;
        @(posedge clk);
        #1;
        if (cyc >= MAXC - 8) begin
            $display("FAIL cycle_budget: got %0d expected below %0d", cyc, MAXC - 8);
            $fatal(1);
        end
        if (v) model_beat(sop, eop, int'(re), int'(im), cyc);
        sink_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
    endtask

    task automatic pulse_reset();
        aclr = 1'b1;
        for (int k = cyc; k < MAXC; k++) begin
            pv_exp[k]  = 1'b0;
            err_exp[k] = 1'b0;
        end
        in_pkt = 1'b0;
        @(posedge clk);
        #1;
        check("rst_peak_valid", 32'(peak_valid), 32'd0);
        check("rst_peak_bin",   32'(peak_bin),   32'd0);
        check("rst_peak_mag",   32'(peak_mag),   32'd0);
        check("rst_error",      32'(error),      32'd0);
        @(posedge clk);
        #1;
        aclr = 1'b0;
    endtask

    logic signed [WIDTH-1:0] pre [64];
    logic signed [WIDTH-1:0] pim [64];
    bit                      psop[64];
    bit                      peop[64];

    task automatic clear_seq();
        for (int i = 0; i < 64; i++) begin
            pre[i] = '0; pim[i] = '0; psop[i] = 1'b0; peop[i] = 1'b0;
        end
    endtask

    task automatic frame16(input int base);
        psop[base]      = 1'b1;
        peop[base + 15] = 1'b1;
    endtask

    // gap: 0 full rate, 1 idle between every beat, 2 random idles
    task automatic send_seq(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && gap == 1) idle(1);
            else if (gap == 2 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            drive(1'b1, psop[i], peop[i], pre[i], pim[i]);
        end
    endtask

    int                 n_pv = 0;
    int                 n_err = 0;
    logic [DEPTH-1:0]   got_bin = '0;
    logic [2*WIDTH-1:0] got_mag = '0;
    int                 hb = 0;
    int                 hm = 0;

    always @(negedge clk) begin
        if (aclr) begin
            hb = 0;
            hm = 0;
        end else if (pv_exp[cyc]) begin
            hb = bin_exp[cyc];
            hm = mag_exp[cyc];
        end
        check("peak_valid", 32'(peak_valid), 32'(pv_exp[cyc]));
        check("error",      32'(error),      32'(err_exp[cyc]));
        check("peak_bin",   32'(peak_bin),   32'(hb));
        check("peak_mag",   32'(peak_mag),   32'(hm));
        if (peak_valid === 1'b1) begin
            n_pv++;
            got_bin = peak_bin;
            got_mag = peak_mag;
        end
        if (error === 1'b1) n_err++;
    end

    task automatic expect_result(input string name, input int pv_d, input int err_d,
                                 input int pv0, input int err0, input int b, input int m);
        check({name, "_pulses"}, 32'(n_pv - pv0),  32'(pv_d));
        check({name, "_errors"}, 32'(n_err - err0), 32'(err_d));
        check({name, "_bin"},    32'(got_bin),      32'(b));
        check({name, "_mag"},    32'(got_mag),      32'(m));
        if (pv_d != 0) begin
            check({name, "_model_bin"}, 32'(m_last_bin), 32'(b));
            check({name, "_model_mag"}, 32'(m_last_mag), 32'(m));
        end
    endtask

    initial begin
        int pv0, err0, mode, n, k, v;
        idle(3);
        check("reset_peak_mag", 32'(peak_mag), 32'd0);
        check("reset_peak_bin", 32'(peak_bin), 32'd0);
        aclr = 1'b0;
        idle(2);

        clear_seq(); frame16(0); pre[5] = 8'sd100; pim[5] = -8'sd50;
        pv0 = n_pv; err0 = n_err;
        send_seq(16, 0); idle(6);
        expect_result("single", 1, 0, pv0, err0, 5, 12500);

        clear_seq(); frame16(0); pre[3] = 8'sd10; pre[9] = 8'sd10;
        pv0 = n_pv; err0 = n_err;
        send_seq(16, 0); idle(6);
        expect_result("tie", 1, 0, pv0, err0, 3, 100);

        clear_seq(); frame16(0); pre[7] = -8'sd128; pim[7] = -8'sd128;
        pv0 = n_pv; err0 = n_err;
        send_seq(16, 0); idle(6);
        expect_result("fullscale", 1, 0, pv0, err0, 7, 32768);
        pv0 = n_pv; err0 = n_err;
        send_seq(16, 1); idle(6);
        expect_result("fullscale_gaps", 1, 0, pv0, err0, 7, 32768);

        clear_seq(); psop[0] = 1'b1; peop[10] = 1'b1; pre[4] = 8'sd90;
        pv0 = n_pv; err0 = n_err;
        send_seq(11, 0); idle(6);
        expect_result("early_eop", 0, 1, pv0, err0, 7, 32768);
        clear_seq(); frame16(0); pre[2] = 8'sd30; pim[2] = 8'sd40;
        pv0 = n_pv; err0 = n_err;
        send_seq(16, 0); idle(6);
        expect_result("after_early", 1, 0, pv0, err0, 2, 2500);

        clear_seq(); psop[0] = 1'b1; pre[2] = 8'sd100; frame16(6); pre[18] = 8'sd50;
        pv0 = n_pv; err0 = n_err;
        send_seq(22, 0); idle(6);
        expect_result("restart", 1, 1, pv0, err0, 12, 2500);

        clear_seq(); frame16(0); pre[0] = 8'sd127; pre[4] = 8'sd20;
        pv0 = n_pv; err0 = n_err;
        send_seq(16, 0); idle(6);
        if (FIRST == 0) expect_result("dc_bin", 1, 0, pv0, err0, 0, 16129);
        else            expect_result("dc_bin", 1, 0, pv0, err0, 4, 400);

        clear_seq(); frame16(0); pre[3] = 8'sd60;
        pv0 = n_pv; err0 = n_err;
        send_seq(9, 0);
        pulse_reset(); idle(6);
        check("aclr_pulses", 32'(n_pv - pv0),  32'd0);
        check("aclr_errors", 32'(n_err - err0), 32'd0);
        check("aclr_mag",    32'(peak_mag),     32'd0);

        for (int it = 0; it < 60; it++) begin
            clear_seq();
            for (int i = 0; i < 64; i++) begin
                if (it % 2 == 0) v = int'($urandom_range(0, 4)) - 2;
                else             v = int'($urandom_range(0, 255));
                pre[i] = 8'(v);
                if (it % 2 == 0) v = int'($urandom_range(0, 4)) - 2;
                else             v = int'($urandom_range(0, 255));
                pim[i] = 8'(v);
            end
            mode = $urandom_range(0, 10);
            n = 16;
            if (mode <= 5) begin
                frame16(0);
            end else if (mode == 6) begin
                k = $urandom_range(1, 14);
                psop[0] = 1'b1; peop[k] = 1'b1; n = k + 1;
            end else if (mode == 7) begin
                k = $urandom_range(1, 14);
                psop[0] = 1'b1; frame16(k); n = k + 16;
            end else if (mode == 8) begin
                psop[0] = 1'b1;
            end else if (mode == 9) begin
                psop[1] = 1'b1; peop[1] = 1'b1; n = 2;
            end else begin
                psop[0] = 1'b1; n = $urandom_range(1, 15);
            end
            send_seq(n, $urandom_range(0, 2));
            if (mode == 10) pulse_reset();
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        idle(8);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
